// File: rtl/sram_controller.sv
// sram_controller: bridges the CPU's 32-bit data memory port onto a 16-bit
// asynchronous SRAM. Each word moves as two half-word SRAM cycles (low half
// first, then high half); the CPU sees a one-cycle ready pulse and a
// combinational stall while an access is in flight.
module sram_controller #(
  parameter int unsigned BASE_ADDR = 1024,
  parameter int unsigned ADDR_W    = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [31:0]       address,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              ready,
  output logic              pause,
  inout  wire  [15:0]       SRAM_DQ,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic              SRAM_WE_N
);

  // Word index width: one SRAM address bit selects the half-word.
  localparam int IDX_W = ADDR_W - 1;

  typedef enum logic [2:0] {
    IDLE,
    WR_LO,
    WR_HI,
    RD_LO,
    RD_HI,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rdata_q, rdata_d;

  logic [IDX_W-1:0] idx_req;
  logic             dq_oe;
  logic [15:0]      dq_out;

  // Word index of the incoming request; the truncation makes addresses past
  // the end of the SRAM (or below the base) wrap around.
  assign idx_req = IDX_W'((address - BASE_ADDR) >> 2);

  // State register and latched request/read data, synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state logic: accept a request in IDLE (write wins), then walk the
  // two half-word cycles and a single DONE cycle.
  // NOTE: every signal written here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (wr_en) begin
          idx_d   = idx_req;
          wdata_d = wdata;
          state_d = WR_LO;
        end else if (rd_en) begin
          idx_d   = idx_req;
          state_d = RD_LO;
        end
      end
      WR_LO: state_d = WR_HI;
      WR_HI: state_d = DONE;
      RD_LO: begin
        rdata_d[15:0] = SRAM_DQ;
        state_d       = RD_HI;
      end
      RD_HI: begin
        rdata_d[31:16] = SRAM_DQ;
        state_d        = DONE;
      end
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // SRAM-side outputs decoded from the registered state and latched request;
  // the address rests on the low half-word outside the HI cycles.
  always_comb begin
    SRAM_ADDR = {idx_q, 1'b0};
    dq_oe     = 1'b0;
    dq_out    = wdata_q[15:0];
    ready     = 1'b0;
    unique case (state_q)
      WR_LO: dq_oe = 1'b1;
      WR_HI: begin
        SRAM_ADDR = {idx_q, 1'b1};
        dq_oe     = 1'b1;
        dq_out    = wdata_q[31:16];
      end
      RD_HI: SRAM_ADDR = {idx_q, 1'b1};
      DONE:  ready = 1'b1;
      default: ;
    endcase
  end

  assign SRAM_WE_N = ~dq_oe;
  assign SRAM_DQ   = dq_oe ? dq_out : 16'hzzzz;
  assign rdata     = rdata_q;
  assign pause     = (rd_en | wr_en) & ~ready;

endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: drives directed and randomized CPU accesses into
// sram_controller attached to a behavioural async SRAM, and compares the
// observed bus/handshake against a word-level reference memory.
module tb_sram_controller;

  localparam int MEM_WORDS = 262144;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, rd_en;
  logic [31:0] address, wdata;
  logic [31:0] rdata;
  logic        ready, pause;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        sram_we_n;

  int tests_run = 0;
  int tests_failed = 0;

  // Physical SRAM model and the bench's reference view of its contents.
  logic [15:0] sram    [MEM_WORDS];
  logic [15:0] ref_mem [MEM_WORDS];
  logic [31:0] rdata_exp;

  sram_controller #(.BASE_ADDR(1024), .ADDR_W(18)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .address   (address),
    .wdata     (wdata),
    .rdata     (rdata),
    .ready     (ready),
    .pause     (pause),
    .SRAM_DQ   (sram_dq),
    .SRAM_ADDR (sram_addr),
    .SRAM_WE_N (sram_we_n)
  );

  always #5 clk = ~clk;

  // Asynchronous SRAM: outputs data whenever not being written, stores the
  // bus value at each clock edge seen with WE_N low.
  assign sram_dq = sram_we_n ? sram[sram_addr] : 16'hzzzz;
  always @(posedge clk) if (!sram_we_n) sram[sram_addr] <= sram_dq;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Low half-word SRAM address of a CPU byte address, straight from the map.
  function automatic logic [17:0] lo_of(input logic [31:0] a);
    logic [31:0] off;
    off = a - 32'd1024;
    return 18'(((off / 4) % 131072) * 2);
  endfunction

  // One complete CPU access starting in an IDLE cycle. Checks pause/ready,
  // SRAM address and WE_N every cycle and rdata in the ready cycle. With
  // scramble set, the CPU inputs are garbled while the access is in flight.
  task automatic access(input bit wr, input bit rd, input logic [31:0] a,
                        input logic [31:0] wd, input bit scramble, input string tag);
    logic [17:0] lo, hi;
    lo = lo_of(a);
    hi = lo | 18'd1;
    wr_en = wr; rd_en = rd; address = a; wdata = wd;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check({tag, "/pause"}, 32'(pause), 32'((wr_en | rd_en) && c != 3));
      check({tag, "/ready"}, 32'(ready), 32'(c == 3));
      if (c >= 1) begin
        check({tag, "/addr"}, 32'(sram_addr), 32'((c == 2) ? hi : lo));
        check({tag, "/we_n"}, 32'(sram_we_n), 32'(!(wr && c < 3)));
      end
      if (c == 3) begin
        if (!wr) rdata_exp = {ref_mem[hi], ref_mem[lo]};
        check({tag, "/rdata"}, rdata, rdata_exp);
      end
      @(posedge clk); #1;
      if (scramble && c < 2) begin
        address = $urandom; wdata = $urandom;
        wr_en = 1'($urandom); rd_en = 1'($urandom);
      end
    end
    if (wr) begin
      ref_mem[lo] = wd[15:0];
      ref_mem[hi] = wd[31:16];
      check({tag, "/mem_lo"}, 32'(sram[lo]), 32'(ref_mem[lo]));
      check({tag, "/mem_hi"}, 32'(sram[hi]), 32'(ref_mem[hi]));
    end
  endtask

  // Quiet cycles with no request: nothing may move on the bus.
  task automatic idle(input int n, input string tag);
    wr_en = 1'b0; rd_en = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check({tag, "/idle_ready"}, 32'(ready), 32'd0);
      check({tag, "/idle_pause"}, 32'(pause), 32'd0);
      check({tag, "/idle_we_n"}, 32'(sram_we_n), 32'd1);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [31:0] a, wd, rst_wd;
    logic [17:0] rlo;
    bit          w, r;

    for (int i = 0; i < MEM_WORDS; i++) begin
      sram[i]    = 16'(i);
      ref_mem[i] = 16'(i);
    end
    rdata_exp = '0;

    // Reset with a write request held: outputs at reset values, pause follows request.
    rst = 1'b1; wr_en = 1'b1; rd_en = 1'b0; address = 32'd1060; wdata = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset/ready", 32'(ready), 32'd0);
    check("reset/we_n",  32'(sram_we_n), 32'd1);
    check("reset/addr",  32'(sram_addr), 32'd0);
    check("reset/rdata", rdata, 32'd0);
    check("reset/pause", 32'(pause), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2, "post_reset");

    // Directed: write, read back, reset-pattern read, simultaneous wr+rd.
    access(1'b1, 1'b0, 32'd1024, 32'hDEAD_BEEF, 1'b0, "t1_write");
    idle(1, "t1");
    access(1'b0, 1'b1, 32'd1024, 32'h0, 1'b0, "t2_read");
    check("t2/value", rdata, 32'hDEAD_BEEF);
    idle(1, "t2");
    access(1'b0, 1'b1, 32'd1028, 32'h0, 1'b0, "t3_read");
    check("t3/value", rdata, 32'h0003_0002);
    idle(1, "t3");
    access(1'b1, 1'b1, 32'd1032, 32'h1234_5678, 1'b0, "t4_wr_rd");
    check("t4/sram4", 32'(sram[4]), 32'h5678);
    check("t4/sram5", 32'(sram[5]), 32'h1234);
    check("t4/rdata_kept", rdata, 32'h0003_0002);
    idle(1, "t4");

    // Reset during WR_HI: abort, no ready, rdata cleared, address back to 0.
    rst_wd = 32'hCAFE_F00D;
    wr_en = 1'b1; rd_en = 1'b0; address = 32'd1040; wdata = rst_wd;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("t5/we_n_in_wr_hi", 32'(sram_we_n), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; wr_en = 1'b0;
    @(negedge clk);
    check("t5/ready", 32'(ready), 32'd0);
    check("t5/we_n",  32'(sram_we_n), 32'd1);
    check("t5/addr",  32'(sram_addr), 32'd0);
    check("t5/rdata", rdata, 32'd0);
    rlo = lo_of(32'd1040);
    ref_mem[rlo]         = rst_wd[15:0];
    ref_mem[rlo | 18'd1] = rst_wd[31:16];
    rdata_exp = '0;
    @(posedge clk); #1;
    idle(4, "t5");

    // Four back-to-back reads with the request held throughout.
    for (int k = 0; k < 4; k++)
      access(1'b0, 1'b1, 32'd1024 + 32'(k * 4), 32'h0, 1'b0, "t6_b2b");
    idle(1, "t6");

    // Randomized mix of reads/writes, gaps, mid-access input noise and wrapping addresses.
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 9) == 0) a = $urandom;
      else a = 32'd1024 + 32'($urandom_range(0, 63) * 4) + 32'($urandom_range(0, 3));
      wd = $urandom;
      w  = 1'($urandom);
      r  = w ? 1'($urandom) : 1'b1;
      access(w, r, a, wd, 1'($urandom), "rand");
      if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 2), "rand");
    end
    idle(2, "final");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
